// File: rtl/link_master_ctrl_pkg.sv
// Shared definitions for the play/level link: FSM encoding, link bit positions
// and the pulse-arbitration helper, reused by the receiver side.
package link_master_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  localparam int PLAY_BIT  = 3;
  localparam int LEVEL_MSB = 2;
  localparam int LEVEL_LSB = 0;
  localparam int LEVEL_W   = LEVEL_MSB - LEVEL_LSB + 1;
  localparam int LINK_W    = PLAY_BIT + 1;

  typedef enum logic [1:0] {
    ACT_NONE = 2'd0,
    ACT_UP   = 2'd1,
    ACT_DOWN = 2'd2,
    ACT_PLAY = 2'd3
  } act_t;

  // Play beats everything; up and down together cancel each other out.
  function automatic act_t resolve_pulses(input logic play, input logic up, input logic down);
    if (play)              return ACT_PLAY;
    else if (up && !down)  return ACT_UP;
    else if (down && !up)  return ACT_DOWN;
    return ACT_NONE;
  endfunction

endpackage

// File: rtl/link_master_ctrl_btn_debounce.sv
// One raw push-button: 2-flop synchronizer, stable-time debouncer and a
// single-cycle press pulse on each debounced 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             deb_q;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: rst sits in the sensitivity list, so every flop clears without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      // NOTE: non-blocking so each stage samples its pre-edge value; blocking would collapse the synchronizer chain.
      sync1_q <= btn;
      sync2_q <= sync1_q;
      press   <= 1'b0;
      if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        deb_q <= sync2_q;
        press <= sync2_q;  // rising debounced edge only; releases stay silent
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/link_master_ctrl.sv
// Play/level controller driving a 4-bit cross-board link, rate-limited by a
// settle window during which the latest request is held pending.
module link_master_ctrl
  import link_master_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SETTLE_CYCLES   = 64,
  parameter int MAX_LEVEL       = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_play,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] data_out,
  output logic       playing,
  output logic [2:0] level,
  output logic       busy
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0]   SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX   = LEVEL_W'(MAX_LEVEL);

  logic play_p, up_p, down_p;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_play (
    .clk(clk), .rst(rst), .btn(btn_play), .press(play_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .btn(btn_up), .press(up_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst(rst), .btn(btn_down), .press(down_p));

  state_t              state_q, state_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [LINK_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic                pend_play_q, pend_play_d;
  act_t                pend_ud_q, pend_ud_d;

  act_t new_act;
  act_t act;
  logic use_pend;
  logic commit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      level_q     <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      settle_q    <= '0;
      pend_play_q <= 1'b0;
      pend_ud_q   <= ACT_NONE;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      settle_q    <= settle_d;
      pend_play_q <= pend_play_d;
      pend_ud_q   <= pend_ud_d;
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
    state_d     = state_q;
    level_d     = level_q;
    data_d      = data_q;
    busy_d      = busy_q;
    settle_d    = settle_q;
    pend_play_d = pend_play_q;
    pend_ud_d   = pend_ud_q;
    act         = ACT_NONE;
    commit      = 1'b0;
    new_act     = resolve_pulses(play_p, up_p, down_p);
    use_pend    = pend_play_q || (pend_ud_q != ACT_NONE);

    if (busy_q) begin
      if (settle_q == '0) busy_d = 1'b0;
      else                settle_d = settle_q - SET_W'(1);
      // Latest request wins; up/down in IDLE are dropped rather than queued.
      if (new_act == ACT_PLAY) begin
        pend_play_d = 1'b1;
      end else if (new_act != ACT_NONE && state_q == PLAY) begin
        pend_ud_d = new_act;
      end
    end else begin
      if (use_pend) begin
        act         = pend_play_q ? ACT_PLAY : pend_ud_q;
        pend_play_d = 1'b0;
        pend_ud_d   = ACT_NONE;
      end else begin
        act = new_act;
      end

      unique case (act)
        ACT_PLAY: begin
          state_d = (state_q == IDLE) ? PLAY : IDLE;
          level_d = '0;
          commit  = 1'b1;
        end
        ACT_UP: begin
          if (state_q == PLAY && level_q < LEVEL_MAX) begin
            level_d = level_q + LEVEL_W'(1);
            commit  = 1'b1;
          end
        end
        ACT_DOWN: begin
          if (state_q == PLAY && level_q != '0) begin
            level_d = level_q - LEVEL_W'(1);
            commit  = 1'b1;
          end
        end
        ACT_NONE: ;
      endcase

      if (commit) begin
        data_d[PLAY_BIT]            = state_d;
        data_d[LEVEL_MSB:LEVEL_LSB] = level_d;
        busy_d                      = 1'b1;
        settle_d                    = SETTLE_LOAD;
      end

      // A pulse arriving while a pending action drains waits its own turn.
      if (use_pend) begin
        if (new_act == ACT_PLAY) begin
          pend_play_d = 1'b1;
        end else if (new_act != ACT_NONE && state_d == PLAY) begin
          pend_ud_d = new_act;
        end
      end
    end
  end

  assign data_out = data_q;
  assign playing  = (state_q == PLAY);
  assign level    = level_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_link_master_ctrl.sv
// Scoreboard bench for link_master_ctrl: an edge-numbered reference model
// predicts each link commit; a negedge monitor compares what the DUT shows.
module tb_link_master_ctrl;

  localparam int D    = 4;
  localparam int S    = 8;
  localparam int MAXL = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btn = '0;  // [0]=play [1]=up [2]=down
  logic [3:0] data_out;
  logic       playing;
  logic [2:0] level;
  logic       busy;

  always #5 clk = ~clk;

  link_master_ctrl #(.DEBOUNCE_CYCLES(D), .SETTLE_CYCLES(S), .MAX_LEVEL(MAXL)) dut (
    .clk(clk), .rst(rst),
    .btn_play(btn[0]), .btn_up(btn[1]), .btn_down(btn[2]),
    .data_out(data_out), .playing(playing), .level(level), .busy(busy));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: edges are numbered from reset release; a button press is
  // recognised after D consecutive differing samples and acts 3 edges later.
  int         edge_n = 0;
  bit         m_deb[3] = '{0, 0, 0};
  int         m_run[3] = '{0, 0, 0};
  int         m_due[3] = '{-1, -1, -1};
  bit         m_playing = 0;
  int         m_level = 0;
  int         m_commit = -1;
  bit         m_pend_play = 0;
  int         m_pend_ud = 0;  // 0 none, 1 up, 2 down; 3 denotes play in actions
  bit         m_busy = 0;
  logic [3:0] sb[$];

  task automatic model_apply(input int a, input int e);
    bit c = 0;
    if (a == 3) begin
      m_playing = !m_playing;
      m_level = 0;
      c = 1;
    end else if (a == 1 && m_playing && m_level < MAXL) begin
      m_level++;
      c = 1;
    end else if (a == 2 && m_playing && m_level > 0) begin
      m_level--;
      c = 1;
    end
    if (c) begin
      m_commit = e;
      sb.push_back({m_playing, 3'(m_level)});
    end
  endtask

  task automatic model_hold(input int nw);
    if (nw == 3) m_pend_play = 1;
    else if (nw != 0 && m_playing) m_pend_ud = nw;
  endtask

  task automatic model_step();
    int  e = edge_n;
    bit  np = (m_due[0] == e);
    bit  nu = (m_due[1] == e);
    bit  nd = (m_due[2] == e);
    int  nw = np ? 3 : (nu && !nd) ? 1 : (nd && !nu) ? 2 : 0;
    bit  busy_in = (m_commit >= 0) && (e > m_commit) && (e <= m_commit + S);
    for (int b = 0; b < 3; b++) begin
      if (btn[b] != m_deb[b]) begin
        m_run[b]++;
        if (m_run[b] == D) begin
          m_deb[b] = btn[b];
          m_run[b] = 0;
          if (btn[b]) m_due[b] = e + 3;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    if (busy_in) begin
      model_hold(nw);
    end else if (m_pend_play || m_pend_ud != 0) begin
      int a = m_pend_play ? 3 : m_pend_ud;
      m_pend_play = 0;
      m_pend_ud = 0;
      model_apply(a, e);
      model_hold(nw);
    end else begin
      model_apply(nw, e);
    end
    m_busy = (m_commit >= 0) && (e >= m_commit) && (e < m_commit + S);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_n = 0;
      m_deb = '{0, 0, 0};
      m_run = '{0, 0, 0};
      m_due = '{-1, -1, -1};
      m_playing = 0;
      m_level = 0;
      m_commit = -1;
      m_pend_play = 0;
      m_pend_ud = 0;
      m_busy = 0;
      sb.delete();
    end else begin
      edge_n++;
      model_step();
    end
  end

  // Monitor: every new link value must be the next predicted commit.
  logic [3:0] last_seen = '0;
  always @(negedge clk) begin
    if (rst) begin
      last_seen = '0;
    end else begin
      check("busy", busy, m_busy);
      check("state", {playing, level}, {m_playing, 3'(m_level)});
      if (data_out !== last_seen) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_commit: got %0h expected no change from %0h at %0t",
                   data_out, last_seen, $time);
        end else begin
          check("data_out", data_out, sb.pop_front());
        end
        last_seen = data_out;
      end
    end
  end

  task automatic press(input int b, input int hold, input int gap);
    @(negedge clk);
    btn[b] = 1'b1;
    repeat (hold) @(negedge clk);
    btn[b] = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  int busy_cnt;
  int guard;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data_out", data_out, 4'h0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;

    // First play press commits on edge D+3, then settles for S cycles.
    @(negedge clk);
    btn[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("play_before_edge7", data_out, 4'h0);
    @(posedge clk);
    #1 check("play_at_edge7", data_out, 4'h8);
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      busy_cnt += int'(busy);
      if (i == 3) btn[0] = 1'b0;
    end
    check("busy_len", busy_cnt, S);

    // Nine up presses saturate at MAX_LEVEL.
    for (int i = 0; i < 9; i++) press(1, 6, 20);
    check("sat_level", level, 3'd7);
    check("sat_data", data_out, 4'hF);

    // Short glitch never debounces.
    @(negedge clk);
    btn[1] = 1'b1;
    repeat (3) @(negedge clk);
    btn[1] = 1'b0;
    repeat (15) @(negedge clk);
    check("glitch_data", data_out, 4'hF);

    // Down to 4, then a down commit (->3) with up and a later down inside its window.
    for (int i = 0; i < 3; i++) press(2, 6, 20);
    check("level4", level, 3'd4);
    fork
      begin
        @(negedge clk);
        btn[2] = 1'b1;
        repeat (4) @(negedge clk);
        btn[2] = 1'b0;
        repeat (4) @(negedge clk);
        btn[2] = 1'b1;
        repeat (5) @(negedge clk);
        btn[2] = 1'b0;
      end
      begin
        @(negedge clk);
        repeat (6) @(negedge clk);
        btn[1] = 1'b1;
        repeat (5) @(negedge clk);
        btn[1] = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    check("pending_overwrite", data_out, 4'hA);

    // Play and up together from level 4: play wins, then up is ignored in IDLE.
    press(1, 6, 20);
    press(1, 6, 20);
    check("level4_again", data_out, 4'hC);
    @(negedge clk);
    btn[0] = 1'b1;
    btn[1] = 1'b1;
    repeat (6) @(negedge clk);
    btn = '0;
    repeat (20) @(negedge clk);
    check("play_wins", data_out, 4'h0);
    press(1, 6, 20);
    press(1, 6, 20);
    check("idle_up_ignored", data_out, 4'h0);

    // Reset in the middle of a settle window at level 5.
    press(0, 6, 20);
    for (int i = 0; i < 4; i++) press(1, 6, 20);
    @(negedge clk);
    btn[1] = 1'b1;
    guard = 0;
    while (!busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("busy_seen", busy, 1'b1);
    check("level5", data_out, 4'hD);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    btn = '0;
    #1;
    check("async_rst_data", data_out, 4'h0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_state", {playing, level}, 4'h0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_quiet", {data_out, busy}, 5'h0);
    end

    // Random button activity, including glitches and overlaps.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 9) == 0) btn[b] = ~btn[b];
    end
    btn = '0;
    repeat (40) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
